// File: rtl/spmm_tile_ctrl_if.sv
// Handshake and datapath-strobe bundle for the SpMM tile controller.
//
// Handshake: a *_start is a one-cycle request. It is taken only if, in that
// same cycle, the controller is in IDLE and the matching ready is high.
// A start that is not taken is dropped, not held. The requester must re-assert
// it. Readies never depend on the starts.
interface spmm_tile_ctrl_if #(
  parameter int N = 16
);
  localparam int LGN = $clog2(N);
  localparam int GW  = $clog2(N / 4);

  logic           lhs_ready_ns;
  logic           lhs_ready_ws;
  logic           lhs_ready_os;
  logic           lhs_ready_wos;
  logic           lhs_start;
  logic           lhs_ws;
  logic           lhs_os;
  logic           rhs_ready;
  logic           rhs_start;
  logic           out_ready;
  logic           out_start;
  logic           lhs_latch;
  logic           rhs_we;
  logic [GW-1:0]  rhs_grp;
  logic           pe_issue;
  logic [LGN-1:0] pe_col;
  logic           acc_we;
  logic           acc_add;
  logic [LGN-1:0] acc_col;
  logic           out_rd_en;
  logic [GW-1:0]  out_grp;
  logic [2:0]     dbg_state;

  // Controller side
  modport slave (
    output lhs_ready_ns, lhs_ready_ws, lhs_ready_os, lhs_ready_wos,
    input  lhs_start, lhs_ws, lhs_os,
    output rhs_ready,
    input  rhs_start,
    output out_ready,
    input  out_start,
    output lhs_latch, rhs_we, rhs_grp, pe_issue, pe_col,
    output acc_we, acc_add, acc_col, out_rd_en, out_grp, dbg_state
  );

  // Requester / observer side
  modport master (
    input  lhs_ready_ns, lhs_ready_ws, lhs_ready_os, lhs_ready_wos,
    output lhs_start, lhs_ws, lhs_os,
    input  rhs_ready,
    output rhs_start,
    input  out_ready,
    output out_start,
    input  lhs_latch, rhs_we, rhs_grp, pe_issue, pe_col,
    input  acc_we, acc_add, acc_col, out_rd_en, out_grp, dbg_state
  );
endinterface

// File: rtl/spmm_tile_ctrl.sv
// SpMM tile sequencer. It loads the RHS buffer, runs N column passes through
// the PE pipeline, captures the results into the accumulator, and reads the
// tile out. The module is control only. dbg_state exposes the FSM state.
module spmm_tile_ctrl #(
  parameter int N        = 16,
  parameter int PE_DELAY = $clog2(N) + 2
) (
  input  logic             clock,
  input  logic             reset,
  spmm_tile_ctrl_if.slave  bus
);
  localparam int LGN = $clog2(N);
  localparam int GW  = $clog2(N / 4);
  localparam logic [GW-1:0]        GRP_LAST = GW'(N / 4 - 1);
  localparam logic [LGN:0]         CNT_END  = (LGN + 1)'(N);
  localparam logic [PE_DELAY-1:0]  DL_TAIL  = PE_DELAY'(1) << (PE_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_COMP  = 3'd2,
    S_DRAIN = 3'd3,
    S_READ  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                rhs_full_q, acc_live_q;
  logic                ws_q, add_q;
  logic [GW-1:0]       grp_q;
  logic [LGN:0]        cnt_q;
  logic                pe_issue_q;
  logic [LGN-1:0]      pe_col_q;
  logic [PE_DELAY-1:0] dl_vld_q;
  logic [LGN-1:0]      dl_col_q [PE_DELAY];

  logic is_idle;
  logic rdy_rhs, rdy_plain, rdy_os, rdy_out, rdy_sel;
  logic lhs_acc, out_acc, rhs_acc;
  logic grp_last, issue_done, drain_done;

  // Readies exist only in IDLE and are forced low while reset is held
  assign is_idle   = (state_q == S_IDLE) && !reset;
  assign rdy_rhs   = is_idle && !rhs_full_q;
  assign rdy_plain = is_idle && rhs_full_q && !acc_live_q;
  // An os multiply with no live tile simply accumulates onto zero
  assign rdy_os    = is_idle && rhs_full_q;
  assign rdy_out   = is_idle && acc_live_q;
  assign rdy_sel   = bus.lhs_os ? rdy_os : rdy_plain;

  // Priority among simultaneous starts: lhs > out > rhs
  assign lhs_acc = bus.lhs_start && rdy_sel;
  assign out_acc = !lhs_acc && bus.out_start && rdy_out;
  assign rhs_acc = !lhs_acc && !out_acc && bus.rhs_start && rdy_rhs;

  assign grp_last   = (grp_q == GRP_LAST);
  assign issue_done = (cnt_q == CNT_END);
  // The last result is leaving the delay line and nothing is behind it
  assign drain_done = dl_vld_q[PE_DELAY-1] && ((dl_vld_q & ~DL_TAIL) == '0);

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (lhs_acc)      state_d = S_COMP;
        else if (out_acc) state_d = S_READ;
        else if (rhs_acc) state_d = S_LOAD;
      end
      S_LOAD:  if (grp_last)   state_d = S_IDLE;
      S_COMP:  if (issue_done) state_d = S_DRAIN;
      S_DRAIN: if (drain_done) state_d = S_IDLE;
      S_READ:  if (grp_last)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: readies, datapath strobes and indices
  always_comb begin
    bus.lhs_ready_ns  = rdy_plain;
    bus.lhs_ready_ws  = rdy_plain;
    bus.lhs_ready_os  = rdy_os;
    bus.lhs_ready_wos = rdy_os;
    bus.rhs_ready     = rdy_rhs;
    bus.out_ready     = rdy_out;
    bus.lhs_latch     = lhs_acc;
    bus.rhs_we        = rhs_acc || (state_q == S_LOAD);
    bus.rhs_grp       = bus.rhs_we ? grp_q : '0;
    bus.out_rd_en     = out_acc || (state_q == S_READ);
    bus.out_grp       = bus.out_rd_en ? grp_q : '0;
    bus.pe_issue      = pe_issue_q;
    bus.pe_col        = pe_col_q;
    bus.acc_we        = dl_vld_q[PE_DELAY-1];
    bus.acc_add       = dl_vld_q[PE_DELAY-1] && add_q;
    bus.acc_col       = dl_col_q[PE_DELAY-1];
    bus.dbg_state     = state_q;
  end

  // Tile status flags and per-multiply mode captured at lhs acceptance
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rhs_full_q <= 1'b0;
      acc_live_q <= 1'b0;
      ws_q       <= 1'b0;
      add_q      <= 1'b0;
    end else begin
      if (lhs_acc) begin
        ws_q  <= bus.lhs_ws;
        // A stale tile (already read out) is overwritten, never added to
        add_q <= bus.lhs_os && acc_live_q;
      end
      if (state_q == S_LOAD && grp_last) rhs_full_q <= 1'b1;
      if (state_q == S_DRAIN && drain_done) begin
        acc_live_q <= 1'b1;
        rhs_full_q <= ws_q;
      end
      if (state_q == S_READ && grp_last) acc_live_q <= 1'b0;
    end
  end

  // Row-group counter shared by load and readout; wraps only on phase exit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grp_q <= '0;
    end else if (rhs_acc || out_acc) begin
      grp_q <= GW'(1);
    end else if (state_q == S_LOAD || state_q == S_READ) begin
      grp_q <= grp_last ? '0 : grp_q + GW'(1);
    end
  end

  // Column issue: pe_col 0..N-1 on the N cycles after lhs acceptance
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pe_issue_q <= 1'b0;
      pe_col_q   <= '0;
      cnt_q      <= '0;
    end else if (lhs_acc) begin
      pe_issue_q <= 1'b1;
      pe_col_q   <= '0;
      cnt_q      <= (LGN + 1)'(1);
    end else if (pe_issue_q) begin
      if (issue_done) begin
        pe_issue_q <= 1'b0;
        cnt_q      <= '0;
      end else begin
        pe_col_q <= cnt_q[LGN-1:0];
        cnt_q    <= cnt_q + (LGN + 1)'(1);
      end
    end
  end

  // PE-latency delay line of {issue, col} feeding the accumulator write port
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dl_vld_q <= '0;
      for (int i = 0; i < PE_DELAY; i++) dl_col_q[i] <= '0;
    end else begin
      dl_vld_q    <= (dl_vld_q << 1) | PE_DELAY'(pe_issue_q);
      dl_col_q[0] <= pe_col_q;
      for (int i = 1; i < PE_DELAY; i++) dl_col_q[i] <= dl_col_q[i-1];
    end
  end
endmodule

// File: tb/tb_spmm_tile_ctrl.sv
// Bench for spmm_tile_ctrl. A tile-level model tracks which operation is in
// flight and when it started. Every strobe is derived from its cycle offset.
module tb_spmm_tile_ctrl;
  localparam int N  = 16;
  localparam int PD = 6;
  localparam int G  = N / 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  spmm_tile_ctrl_if #(.N(N)) bus ();
  spmm_tile_ctrl #(.N(N), .PE_DELAY(PD)) dut (.clock(clock), .reset(reset), .bus(bus));

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Model: op 0 none, 1 rhs load, 2 multiply, 3 readout
  int op     = 0;
  int op_t   = 0;
  int op_end = 0;
  bit m_rhs_full, m_acc_live, m_ws, m_add;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    op = 0;
    m_rhs_full = 1'b0;
    m_acc_live = 1'b0;
    m_ws = 1'b0;
    m_add = 1'b0;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, ".rdy"}, {bus.lhs_ready_ns, bus.lhs_ready_ws, bus.lhs_ready_os,
                        bus.lhs_ready_wos, bus.rhs_ready, bus.out_ready}, 0);
    chk({tag, ".strb"}, {bus.lhs_latch, bus.rhs_we, bus.pe_issue, bus.acc_we,
                         bus.acc_add, bus.out_rd_en}, 0);
  endtask

  // One clock cycle: drive starts, check every output against the model
  task automatic step(bit l, bit ws, bit os, bit r, bit o);
    bit idle, e_rhs, e_plain, e_os, e_out, sel, acc_l, acc_o, acc_r;
    bit e_rwe, e_iss, e_awe, e_ord;
    int d;
    @(negedge clock);
    bus.lhs_start = l;
    bus.lhs_ws    = ws;
    bus.lhs_os    = os;
    bus.rhs_start = r;
    bus.out_start = o;
    #1;
    if (op != 0 && cyc >= op_end) begin
      case (op)
        1: m_rhs_full = 1'b1;
        2: begin m_acc_live = 1'b1; m_rhs_full = m_ws; end
        3: m_acc_live = 1'b0;
        default: ;
      endcase
      op = 0;
    end
    idle    = (op == 0);
    e_rhs   = idle && !m_rhs_full;
    e_plain = idle && m_rhs_full && !m_acc_live;
    e_os    = idle && m_rhs_full;
    e_out   = idle && m_acc_live;
    chk("rhs_ready", bus.rhs_ready, e_rhs);
    chk("lhs_ready_ns", bus.lhs_ready_ns, e_plain);
    chk("lhs_ready_ws", bus.lhs_ready_ws, e_plain);
    chk("lhs_ready_os", bus.lhs_ready_os, e_os);
    chk("lhs_ready_wos", bus.lhs_ready_wos, e_os);
    chk("out_ready", bus.out_ready, e_out);
    sel   = os ? e_os : e_plain;
    acc_l = l && sel;
    acc_o = !acc_l && o && e_out;
    acc_r = !acc_l && !acc_o && r && e_rhs;
    if (acc_l) begin
      op = 2; op_t = cyc; op_end = cyc + N + PD + 1;
      m_ws = ws; m_add = os && m_acc_live;
    end else if (acc_o) begin
      op = 3; op_t = cyc; op_end = cyc + G;
    end else if (acc_r) begin
      op = 1; op_t = cyc; op_end = cyc + G;
    end
    d     = cyc - op_t;
    e_rwe = (op == 1) && d < G;
    e_iss = (op == 2) && d >= 1 && d <= N;
    e_awe = (op == 2) && d >= 1 + PD && d <= N + PD;
    e_ord = (op == 3) && d < G;
    chk("lhs_latch", bus.lhs_latch, acc_l);
    chk("rhs_we", bus.rhs_we, e_rwe);
    if (e_rwe) chk("rhs_grp", bus.rhs_grp, d);
    chk("pe_issue", bus.pe_issue, e_iss);
    if (e_iss) chk("pe_col", bus.pe_col, d - 1);
    chk("acc_we", bus.acc_we, e_awe);
    if (e_awe) chk("acc_col", bus.acc_col, d - 1 - PD);
    chk("acc_add", bus.acc_add, e_awe && m_add);
    chk("out_rd_en", bus.out_rd_en, e_ord);
    if (e_ord) chk("out_grp", bus.out_grp, d);
    @(posedge clock);
    cyc++;
  endtask

  task automatic idle_n(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset in the middle of a cycle, held for a few edges
  task automatic apply_reset(int hold);
    @(negedge clock);
    bus.lhs_start = 0; bus.rhs_start = 0; bus.out_start = 0;
    #2 reset = 1'b1;
    #1;
    chk_all_zero("in_reset");
    model_reset();
    repeat (hold) @(posedge clock);
    #1;
    chk_all_zero("reset_held");
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    bus.lhs_start = 0; bus.lhs_ws = 0; bus.lhs_os = 0;
    bus.rhs_start = 0; bus.out_start = 0;
    reset = 1'b1;
    model_reset();
    #1;
    chk_all_zero("por");
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Idle after reset: only rhs_ready
    idle_n(3);
    // RHS load, then a plain multiply
    step(0, 0, 0, 1, 0);
    idle_n(5);
    step(1, 0, 0, 0, 0);
    idle_n(25);
    // Readout of that tile
    step(0, 0, 0, 0, 1);
    idle_n(5);
    // Weight-stationary tile, then an accumulating tile on the kept buffer
    step(0, 0, 0, 1, 0);
    idle_n(5);
    step(1, 1, 0, 0, 0);
    idle_n(25);
    step(1, 0, 1, 0, 0);
    idle_n(25);
    // Reload, then lhs/out/rhs together; out while busy must be dropped
    step(0, 0, 0, 1, 0);
    idle_n(5);
    step(1, 1, 1, 1, 1);
    idle_n(2);
    step(0, 0, 0, 0, 1);
    idle_n(24);
    step(0, 0, 0, 0, 1);
    idle_n(5);
    // Reset in the middle of a compute
    step(1, 0, 0, 0, 0);
    idle_n(9);
    apply_reset(2);
    idle_n(30);

    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        apply_reset($urandom_range(1, 3));
      end else begin
        step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
             $urandom_range(0, 5) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
